// File: rtl/cntr_sweep_ctrl.sv
// cntr_sweep_ctrl
// Sequencer for an external 8-bit up/down counter. On start it latches the
// sweep limits, steers the counter to lo_lim, then ramps it as a triangle
// between lo_lim and hi_lim, dwelling at each limit. Completed sweeps are
// counted and a done pulse marks normal completion. Stops are predicted one
// count early, so the counter never overshoots a limit.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, abort      one-cycle run request / immediate stop to IDLE
//   lo_lim, hi_lim    sweep limits (WIDTH)
//   dwell             hold cycles at each limit, 0 = none (DWELL_W)
//   loops             sweeps to run, 0 = continuous (LOOP_W)
//   cntr_in           registered counter value fed back (WIDTH)
//   en, up_down, hold counter controls
//   busy, done, err   status; err is sticky until the next accepted start
//   sweep_cnt         completed sweeps, saturating at 255
module cntr_sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
  input  logic [WIDTH-1:0]   cntr_in,
  output logic               en,
  output logic               up_down,
  output logic               hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_RAMP_UP, S_DWELL_HI, S_RAMP_DN, S_DWELL_LO, S_DONE
  } state_t;

  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic [DWELL_W-1:0] r_dwell, r_dwell_cnt, w_dwell_cnt_nxt;
  logic [LOOP_W-1:0]  r_loops;
  logic               r_dir, w_dir_nxt;
  logic [7:0]         r_sweep, w_sweep_nxt, w_sweep_inc;
  logic               r_err, w_err_nxt;
  logic               w_latch;
  logic               r_en, r_up_down, r_hold, r_busy, r_done;
  logic               w_en_nxt, w_up_down_nxt, w_hold_nxt, w_busy_nxt, w_done_nxt;

  // Stop prediction is done one bit wider so limits at 0 or all-ones
  // cannot alias through wrap-around.
  logic [WIDTH:0] w_cntr_x, w_lo_x, w_hi_x;
  logic           w_moving, w_up_to_lo, w_dn_to_lo, w_up_to_hi;

  assign w_cntr_x    = {1'b0, cntr_in};
  assign w_lo_x      = {1'b0, r_lo};
  assign w_hi_x      = {1'b0, r_hi};
  assign w_moving    = r_en & ~r_hold;
  assign w_up_to_lo  = (w_cntr_x + ONE_X) == w_lo_x;
  assign w_dn_to_lo  = w_cntr_x == (w_lo_x + ONE_X);
  assign w_up_to_hi  = (w_cntr_x + ONE_X) == w_hi_x;
  assign w_sweep_inc = (r_sweep == 8'hFF) ? r_sweep : r_sweep + 8'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_sweep_nxt     = r_sweep;
    w_err_nxt       = r_err;
    w_dir_nxt       = r_dir;
    w_latch         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_latch     = 1'b1;
          w_sweep_nxt = '0;
          if (lo_lim >= hi_lim) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b0;
            if (cntr_in == lo_lim) begin
              w_state_nxt = S_RAMP_UP;
            end else begin
              w_state_nxt = S_SEEK;
              w_dir_nxt   = (cntr_in < lo_lim);
            end
          end
        end
      end
      S_SEEK: begin
        if (w_moving && (r_dir ? w_up_to_lo : w_dn_to_lo)) w_state_nxt = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (w_moving && w_up_to_hi) begin
          if (r_dwell != '0) begin
            w_state_nxt     = S_DWELL_HI;
            w_dwell_cnt_nxt = r_dwell;
          end else begin
            w_state_nxt = S_RAMP_DN;
          end
        end
      end
      S_DWELL_HI: begin
        if (r_dwell_cnt == DWELL_W'(1)) w_state_nxt = S_RAMP_DN;
        else w_dwell_cnt_nxt = r_dwell_cnt - DWELL_W'(1);
      end
      S_RAMP_DN: begin
        if (w_moving && w_dn_to_lo) begin
          w_sweep_nxt = w_sweep_inc;
          if (r_loops != '0 && w_sweep_inc == 8'(r_loops)) begin
            w_state_nxt = S_DONE;
          end else if (r_dwell != '0) begin
            w_state_nxt     = S_DWELL_LO;
            w_dwell_cnt_nxt = r_dwell;
          end else begin
            w_state_nxt = S_RAMP_UP;
          end
        end
      end
      S_DWELL_LO: begin
        if (r_dwell_cnt == DWELL_W'(1)) w_state_nxt = S_RAMP_UP;
        else w_dwell_cnt_nxt = r_dwell_cnt - DWELL_W'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides any transition taken above, including a sweep-ending
    // stop, so the sweep count is left untouched.
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_sweep_nxt = r_sweep;
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge that the state does.
    w_en_nxt      = (w_state_nxt == S_SEEK) || (w_state_nxt == S_RAMP_UP) ||
                    (w_state_nxt == S_RAMP_DN);
    w_up_down_nxt = (w_state_nxt == S_SEEK) ? w_dir_nxt : (w_state_nxt == S_RAMP_UP);
    w_hold_nxt    = (w_state_nxt == S_DWELL_HI) || (w_state_nxt == S_DWELL_LO);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_dwell     <= '0;
      r_loops     <= '0;
      r_dwell_cnt <= '0;
      r_dir       <= 1'b0;
      r_sweep     <= '0;
      r_err       <= 1'b0;
      r_en        <= 1'b0;
      r_up_down   <= 1'b0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_dir       <= w_dir_nxt;
      r_sweep     <= w_sweep_nxt;
      r_err       <= w_err_nxt;
      r_en        <= w_en_nxt;
      r_up_down   <= w_up_down_nxt;
      r_hold      <= w_hold_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      if (w_latch) begin
        r_lo    <= lo_lim;
        r_hi    <= hi_lim;
        r_dwell <= dwell;
        r_loops <= loops;
      end
    end
  end

  assign en        = r_en;
  assign up_down   = r_up_down;
  assign hold      = r_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign sweep_cnt = r_sweep;

endmodule

// File: tb/tb_cntr_sweep_ctrl.sv
// Directed bench for cntr_sweep_ctrl with a behavioural 8-bit up/down
// counter closing the loop through cntr_in.
module tb_cntr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo_lim = '0;
  logic [7:0] hi_lim = '0;
  logic [3:0] dwell = '0;
  logic [3:0] loops = '0;
  logic       en, up_down, hold, busy, done, err;
  logic [7:0] sweep_cnt;

  logic       m_load = 1'b0;
  logic [7:0] m_load_val = '0;
  logic [7:0] m_cnt = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Basic run (cntr=0, lo=2, hi=5, dwell=2, loops=1): counter value and
  // {en,up_down,hold,busy,done} for each cycle after the start edge.
  logic [7:0] exp_cnt [0:10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd4, 8'd3, 8'd2};
  logic [4:0] exp_st  [0:10] = '{5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11010,
                                 5'b00110, 5'b00110, 5'b10010, 5'b10010, 5'b10010,
                                 5'b00011};
  logic [7:0] pat_cont [0:3] = '{8'd10, 8'd11, 8'd12, 8'd11};

  cntr_sweep_ctrl #(.WIDTH(8), .DWELL_W(4), .LOOP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .dwell(dwell), .loops(loops),
    .cntr_in(m_cnt), .en(en), .up_down(up_down), .hold(hold),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (m_load) m_cnt <= m_load_val;
    else if (en && !hold) m_cnt <= up_down ? m_cnt + 8'd1 : m_cnt - 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [7:0] v);
    m_load = 1'b1; m_load_val = v;
    step();
    m_load = 1'b0;
  endtask

  task automatic set_lims(input logic [7:0] lo, input logic [7:0] hi,
                          input logic [3:0] dw, input logic [3:0] lp);
    lo_lim = lo; hi_lim = hi; dwell = dw; loops = lp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_lims(8'd1, 8'd5, 4'd0, 4'd1);
    start = 1'b1;
    load_cnt(8'd0);
    step();
    n_cmp++;
    if ({en, up_down, hold, busy, done, err} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=000000", {en, up_down, hold, busy, done, err});
    end
    n_cmp++;
    if (sweep_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_sweep got=%0d want=0", sweep_cnt);
    end
    start = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++;
    if ({busy, en, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_start_ignored got=%b want=000", {busy, en, err});
    end
  endtask

  // Shared by the basic run and the start-while-busy run; mid_start injects
  // a conflicting start with different limits partway through.
  task automatic run_basic(input bit mid_start, input string tag);
    int n_done = 0;
    load_cnt(8'd0);
    set_lims(8'd2, 8'd5, 4'd2, 4'd1);
    pulse_start();
    for (int k = 0; k <= 10; k++) begin
      n_cmp++;
      if (m_cnt !== exp_cnt[k]) begin
        n_fail++; $display("FAIL %s_cnt[%0d] got=%0d want=%0d", tag, k, m_cnt, exp_cnt[k]);
      end
      n_cmp++;
      if ({en, up_down, hold, busy, done} !== exp_st[k]) begin
        n_fail++; $display("FAIL %s_ctl[%0d] got=%b want=%b", tag, k, {en, up_down, hold, busy, done}, exp_st[k]);
      end
      if (done) n_done++;
      if (mid_start && k == 3) begin
        start = 1'b1;
        set_lims(8'd0, 8'd9, 4'd0, 4'd3);
      end
      if (k == 4) start = 1'b0;
      if (k < 10) step();
    end
    step();
    n_cmp++;
    if (n_done !== 1) begin
      n_fail++; $display("FAIL %s_done_count got=%0d want=1", tag, n_done);
    end
    n_cmp++;
    if ({busy, done, en, hold, err} !== 5'b00000 || sweep_cnt !== 8'd1 || m_cnt !== 8'd2) begin
      n_fail++; $display("FAIL %s_end got=%b/%0d/%0d want=00000/1/2", tag, {busy, done, en, hold, err}, sweep_cnt, m_cnt);
    end
    step();
    n_cmp++;
    if (m_cnt !== 8'd2) begin
      n_fail++; $display("FAIL %s_holds got=%0d want=2", tag, m_cnt);
    end
  endtask

  task automatic test_basic();
    run_basic(1'b0, "basic");
  endtask

  task automatic test_continuous();
    bit saw_done = 1'b0;
    load_cnt(8'd10);
    set_lims(8'd10, 8'd12, 4'd0, 4'd0);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (m_cnt !== pat_cont[k % 4]) begin
        n_fail++; $display("FAIL cont_cnt[%0d] got=%0d want=%0d", k, m_cnt, pat_cont[k % 4]);
      end
      if (done) saw_done = 1'b1;
      step();
    end
    n_cmp++;
    if (sweep_cnt !== 8'd4 || m_cnt !== 8'd10 || {en, up_down, busy} !== 3'b111) begin
      n_fail++; $display("FAIL cont_before_abort got=%0d/%0d/%b want=4/10/111", sweep_cnt, m_cnt, {en, up_down, busy});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (done) saw_done = 1'b1;
    n_cmp++;
    if ({en, hold, busy, done} !== 4'b0000 || sweep_cnt !== 8'd4 || m_cnt !== 8'd11) begin
      n_fail++; $display("FAIL cont_abort got=%b/%0d/%0d want=0000/4/11", {en, hold, busy, done}, sweep_cnt, m_cnt);
    end
    step();
    if (done) saw_done = 1'b1;
    n_cmp++;
    if (m_cnt !== 8'd11) begin
      n_fail++; $display("FAIL cont_stopped got=%0d want=11", m_cnt);
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL cont_no_done got=%b want=0", saw_done);
    end
  endtask

  task automatic test_invalid();
    set_lims(8'd7, 8'd7, 4'd0, 4'd1);
    pulse_start();
    n_cmp++;
    if ({busy, err, en} !== 3'b010) begin
      n_fail++; $display("FAIL inv_err got=%b want=010", {busy, err, en});
    end
    step(); step(); step();
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_fail++; $display("FAIL inv_sticky got=%b want=01", {busy, err});
    end
    // hi-lo == 1 with the counter already on lo: one-cycle ramps.
    load_cnt(8'd11);
    set_lims(8'd11, 8'd12, 4'd0, 4'd1);
    pulse_start();
    n_cmp++;
    if ({en, up_down, hold, busy, done, err} !== 6'b110100 || m_cnt !== 8'd11) begin
      n_fail++; $display("FAIL inv_restart got=%b/%0d want=110100/11", {en, up_down, hold, busy, done, err}, m_cnt);
    end
    step();
    n_cmp++;
    if ({en, up_down, hold, busy, done} !== 5'b10010 || m_cnt !== 8'd12) begin
      n_fail++; $display("FAIL narrow_top got=%b/%0d want=10010/12", {en, up_down, hold, busy, done}, m_cnt);
    end
    step();
    n_cmp++;
    if ({en, busy, done} !== 3'b011 || m_cnt !== 8'd11 || sweep_cnt !== 8'd1) begin
      n_fail++; $display("FAIL narrow_done got=%b/%0d/%0d want=011/11/1", {en, busy, done}, m_cnt, sweep_cnt);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL narrow_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_edges();
    bit bad = 1'b0;
    load_cnt(8'd200);
    set_lims(8'd254, 8'd255, 4'd0, 4'd1);
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      if (m_cnt < 8'd200) bad = 1'b1;
      if (k == 0) begin
        n_cmp++;
        if ({en, up_down, busy} !== 3'b111) begin
          n_fail++; $display("FAIL hi_seek_dir got=%b want=111", {en, up_down, busy});
        end
      end
      if (k == 54 || k == 55 || k == 56) begin
        n_cmp++;
        if (m_cnt !== ((k == 55) ? 8'd255 : 8'd254)) begin
          n_fail++; $display("FAIL hi_cnt[%0d] got=%0d want=%0d", k, m_cnt, (k == 55) ? 255 : 254);
        end
      end
      if (k == 56) begin
        n_cmp++;
        if ({en, up_down, hold, busy, done} !== 5'b00011) begin
          n_fail++; $display("FAIL hi_done got=%b want=00011", {en, up_down, hold, busy, done});
        end
      end
      if (k == 57) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL hi_idle got=%b want=0", busy);
        end
      end
      step();
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL hi_wrap got=%b want=0", bad);
    end

    bad = 1'b0;
    load_cnt(8'd200);
    set_lims(8'd0, 8'd3, 4'd0, 4'd1);
    pulse_start();
    for (int k = 0; k < 210; k++) begin
      if (m_cnt > 8'd200) bad = 1'b1;
      if (k == 0) begin
        n_cmp++;
        if ({en, up_down, busy} !== 3'b101) begin
          n_fail++; $display("FAIL lo_seek_dir got=%b want=101", {en, up_down, busy});
        end
      end
      if (k == 200) begin
        n_cmp++;
        if (m_cnt !== 8'd0 || {en, up_down} !== 2'b11) begin
          n_fail++; $display("FAIL lo_bottom got=%0d/%b want=0/11", m_cnt, {en, up_down});
        end
      end
      if (k == 203) begin
        n_cmp++;
        if (m_cnt !== 8'd3) begin
          n_fail++; $display("FAIL lo_top got=%0d want=3", m_cnt);
        end
      end
      if (k == 206) begin
        n_cmp++;
        if (m_cnt !== 8'd0 || {en, busy, done} !== 3'b011) begin
          n_fail++; $display("FAIL lo_done got=%0d/%b want=0/011", m_cnt, {en, busy, done});
        end
      end
      step();
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL lo_underflow got=%b want=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    run_basic(1'b1, "busy");
    set_lims(8'd1, 8'd9, 4'd0, 4'd1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if ({en, busy, done, err} !== 4'b0000 || sweep_cnt !== 8'd1) begin
      n_fail++; $display("FAIL start_abort got=%b/%0d want=0000/1", {en, busy, done, err}, sweep_cnt);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || m_cnt !== 8'd2) begin
      n_fail++; $display("FAIL start_abort_idle got=%b/%0d want=0/2", busy, m_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_invalid();
    test_edges();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
